// File: rtl/key_pkg.sv
// Shared key indices and default timing for the push-button conditioning path.
// The game-logic stage imports the same constants.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_UP    = 2'd0,
        KEY_DOWN  = 2'd1,
        KEY_LEFT  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_idx_e;

    localparam int NUM_KEYS = 4;

    // 10 ms of stability at 50 MHz; the counter width must cover DEBOUNCE_CYCLES.
    localparam int DEBOUNCE_CYCLES_DEF     = 500000;
    localparam int DEBOUNCE_CNT_W_DEF      = 20;
    localparam int REPEAT_DELAY_FRAMES_DEF = 20;
    localparam int REPEAT_RATE_FRAMES_DEF  = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, stability counter, accepted level and
// a one-cycle pulse on each accepted 0->1 transition.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = DEBOUNCE_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("key_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            cnt         <= '0;
            level_out   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync_q1     <= raw_in;
            sync_q2     <= sync_q1;
            press_pulse <= 1'b0;
            // Any return to the accepted level (a bounce) restarts the stability window.
            if (sync_q2 == level_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                level_out   <= sync_q2;
                press_pulse <= sync_q2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Four debounced keys feeding sticky per-frame event flags cleared by draw_finish.
// Frame-paced auto-repeat is built only when AUTO_REPEAT_EN is defined.
module key_input_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W               = DEBOUNCE_CNT_W_DEF,
    parameter int REPEAT_DELAY_FRAMES = REPEAT_DELAY_FRAMES_DEF,
    parameter int REPEAT_RATE_FRAMES  = REPEAT_RATE_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn_raw,
    input  logic                draw_finish,
    output logic [NUM_KEYS-1:0] op_keys,
    output logic [NUM_KEYS-1:0] key_level
);

    if (REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_bad_repeat
        $error("key_input_ctrl: repeat frame counts must be at least 1");
    end

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] key_evt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .raw_in     (btn_raw[i]),
            .level_out  (level[i]),
            .press_pulse(press[i])
        );
    end

    assign key_level = level;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY_FRAMES, REPEAT_RATE_FRAMES)) + 1;
    localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY_FRAMES);
    localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE_FRAMES);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

    logic [RPT_W-1:0]    rpt_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_first_done;
    logic [NUM_KEYS-1:0] rpt_hit;
    logic [NUM_KEYS-1:0] rpt_evt;

    always_comb begin
        rpt_hit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            rpt_hit[k] = (rpt_cnt[k] + RPT_ONE) == (rpt_first_done[k] ? RPT_RATE : RPT_DELAY);
        end
    end

    // The repeat fires in the draw_finish cycle itself, so set-wins keeps it for the coming frame.
    assign rpt_evt = level & ~press & rpt_hit & {NUM_KEYS{draw_finish}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rpt_cnt[k] <= '0;
            end
            rpt_first_done <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (!level[k] || press[k]) begin
                    rpt_cnt[k]        <= '0;
                    rpt_first_done[k] <= 1'b0;
                end else if (draw_finish) begin
                    if (rpt_hit[k]) begin
                        rpt_cnt[k]        <= '0;
                        rpt_first_done[k] <= 1'b1;
                    end else begin
                        rpt_cnt[k] <= rpt_cnt[k] + RPT_ONE;
                    end
                end
            end
        end
    end

    assign key_evt = press | rpt_evt;
`else
    assign key_evt = press;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_keys <= '0;
        end else begin
            op_keys <= key_evt | (op_keys & ~{NUM_KEYS{draw_finish}});
        end
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with short debounce and repeat timing.
module tb_key_input_ctrl;
    import key_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       draw_finish;
    logic [3:0] op_keys;
    logic [3:0] key_level;

    int n_pass  = 0;
    int n_total = 0;
    bit df_run  = 1'b0;
    int df_phase = 0;

    key_input_ctrl #(
        .DEBOUNCE_CYCLES    (8),
        .CNT_W              (4),
        .REPEAT_DELAY_FRAMES(3),
        .REPEAT_RATE_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .draw_finish(draw_finish),
        .op_keys    (op_keys),
        .key_level  (key_level)
    );

    always #5 clk = ~clk;

    // Frame strobe: one cycle high every 50 cycles, changed on the falling edge.
    initial begin
        draw_finish = 1'b0;
        forever begin
            @(negedge clk);
            df_phase    = (df_phase == 49) ? 0 : df_phase + 1;
            draw_finish = df_run && (df_phase == 49);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that consumed a draw_finish; the next one is 50 edges later.
    task automatic wait_df();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (draw_finish === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL wait_df: draw_finish seen=%0d required=1", seen);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) tick();
        n_total++;
        if (op_keys !== 4'b0000) $display("FAIL reset_op_keys: got %b expected 0000", op_keys);
        else n_pass++;
        n_total++;
        if (key_level !== 4'b0000) $display("FAIL reset_key_level: got %b expected 0000", key_level);
        else n_pass++;
        rst    = 1'b0;
        df_run = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_single_press();
        wait_df();
        btn_raw[KEY_LEFT] = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 9) begin
                n_total++;
                if (key_level !== 4'b0000) $display("FAIL t1_level_early: got %b expected 0000", key_level);
                else n_pass++;
            end
            if (n == 10) begin
                n_total++;
                if (key_level !== 4'b0100) $display("FAIL t1_level: got %b expected 0100", key_level);
                else n_pass++;
                n_total++;
                if (op_keys !== 4'b0000) $display("FAIL t1_op_early: got %b expected 0000", op_keys);
                else n_pass++;
            end
            if (n == 11 || n == 49) begin
                n_total++;
                if (op_keys !== 4'b0100) $display("FAIL t1_op_set n=%0d: got %b expected 0100", n, op_keys);
                else n_pass++;
            end
            if (n == 50) begin
                n_total++;
                if (op_keys !== 4'b0000) $display("FAIL t1_op_clear: got %b expected 0000", op_keys);
                else n_pass++;
            end
        end
        btn_raw[KEY_LEFT] = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_bounce();
        int quiet_bad = 0;
        int rel_bad   = 0;
        wait_df();
        btn_raw[KEY_UP] = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            tick();
            if (n < 50 && (key_level[KEY_UP] !== 1'b0 || op_keys[KEY_UP] !== 1'b0)) quiet_bad++;
            if (n == 50) begin
                n_total++;
                if (key_level[KEY_UP] !== 1'b1) $display("FAIL t2_level: got %b expected 1", key_level[KEY_UP]);
                else n_pass++;
                n_total++;
                if (op_keys[KEY_UP] !== 1'b0) $display("FAIL t2_op_early: got %b expected 0", op_keys[KEY_UP]);
                else n_pass++;
            end
            if (n == 51 || n == 99) begin
                n_total++;
                if (op_keys !== 4'b0001) $display("FAIL t2_op_set n=%0d: got %b expected 0001", n, op_keys);
                else n_pass++;
            end
            if (n == 100) begin
                n_total++;
                if (op_keys[KEY_UP] !== 1'b0) $display("FAIL t2_op_clear: got %b expected 0", op_keys[KEY_UP]);
                else n_pass++;
            end
            if (n > 100 && op_keys[KEY_UP] !== 1'b0) rel_bad++;
            if (n == 115) begin
                n_total++;
                if (key_level[KEY_UP] !== 1'b0) $display("FAIL t2_release_level: got %b expected 0", key_level[KEY_UP]);
                else n_pass++;
            end
            if (n <= 40 && n % 5 == 0) btn_raw[KEY_UP] = ((n / 5) % 2 == 0);
            if (n == 100) btn_raw[KEY_UP] = 1'b0;
        end
        n_total++;
        if (quiet_bad != 0) $display("FAIL t2_bounce_quiet: bad_cycles=%0d expected 0", quiet_bad);
        else n_pass++;
        n_total++;
        if (rel_bad != 0) $display("FAIL t2_release_no_event: bad_cycles=%0d expected 0", rel_bad);
        else n_pass++;
    endtask

    task automatic test_frame_collision();
        wait_df();
        for (int n = 1; n <= 115; n++) begin
            tick();
            if (n == 49) begin
                n_total++;
                if (key_level[KEY_DOWN] !== 1'b1 || op_keys[KEY_DOWN] !== 1'b0)
                    $display("FAIL t3_pre: level=%b op=%b expected level=1 op=0", key_level[KEY_DOWN], op_keys[KEY_DOWN]);
                else n_pass++;
            end
            if (n == 50 || n == 99) begin
                n_total++;
                if (op_keys !== 4'b0010) $display("FAIL t3_set_wins n=%0d: got %b expected 0010", n, op_keys);
                else n_pass++;
            end
            if (n == 100) begin
                n_total++;
                if (op_keys !== 4'b0000) $display("FAIL t3_clear_next: got %b expected 0000", op_keys);
                else n_pass++;
            end
            if (n == 39) btn_raw[KEY_DOWN] = 1'b1;
            if (n == 100) btn_raw[KEY_DOWN] = 1'b0;
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_bit;
        wait_df();
        btn_raw[KEY_RIGHT] = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (n == 11) begin
                n_total++;
                if (op_keys !== 4'b1000) $display("FAIL t4_press: got %b expected 1000", op_keys);
                else n_pass++;
            end
            if (n % 50 == 0) begin
`ifdef AUTO_REPEAT_EN
                exp_bit = (n == 150 || n == 250 || n == 350 || n == 450);
`else
                exp_bit = 1'b0;
`endif
                n_total++;
                if (op_keys[KEY_RIGHT] !== exp_bit)
                    $display("FAIL t4_frame n=%0d: got %b expected %b", n, op_keys[KEY_RIGHT], exp_bit);
                else n_pass++;
            end
            if (n == 510) btn_raw[KEY_RIGHT] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_op;
        wait_df();
        btn_raw[KEY_RIGHT] = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            tick();
            if (n == 155) btn_raw[KEY_UP] = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        exp_op = 4'b1000;
`else
        exp_op = 4'b0000;
`endif
        n_total++;
        if (op_keys !== exp_op) $display("FAIL t5_pre_op: got %b expected %b", op_keys, exp_op);
        else n_pass++;
        n_total++;
        if (key_level !== 4'b1000) $display("FAIL t5_pre_level: got %b expected 1000", key_level);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (op_keys !== 4'b0000 || key_level !== 4'b0000)
            $display("FAIL t5_async: op=%b level=%b expected 0000/0000", op_keys, key_level);
        else n_pass++;
        repeat (3) tick();
        rst = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 9) begin
                n_total++;
                if (key_level !== 4'b0000) $display("FAIL t5_fresh_early: got %b expected 0000", key_level);
                else n_pass++;
            end
            if (n == 10) begin
                n_total++;
                if (key_level !== 4'b1001) $display("FAIL t5_fresh_level: got %b expected 1001", key_level);
                else n_pass++;
                n_total++;
                if (op_keys !== 4'b0000) $display("FAIL t5_fresh_op_early: got %b expected 0000", op_keys);
                else n_pass++;
            end
            if (n == 11) begin
                n_total++;
                if (op_keys !== 4'b1001) $display("FAIL t5_fresh_op: got %b expected 1001", op_keys);
                else n_pass++;
            end
        end
        btn_raw = 4'b0000;
        repeat (15) tick();
    endtask

    task automatic test_all_keys();
        wait_df();
        btn_raw = 4'b1111;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 10) begin
                n_total++;
                if (key_level !== 4'b1111 || op_keys !== 4'b0000)
                    $display("FAIL t6_pre: level=%b op=%b expected 1111/0000", key_level, op_keys);
                else n_pass++;
            end
            if (n == 11 || n == 49) begin
                n_total++;
                if (op_keys !== 4'b1111) $display("FAIL t6_all_set n=%0d: got %b expected 1111", n, op_keys);
                else n_pass++;
            end
            if (n == 50) begin
                n_total++;
                if (op_keys !== 4'b0000) $display("FAIL t6_all_clear: got %b expected 0000", op_keys);
                else n_pass++;
            end
        end
        btn_raw = 4'b0000;
        repeat (15) tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_frame_collision();
        test_auto_repeat();
        test_async_reset();
        test_all_keys();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
